// File: rtl/pid_bus_frontend.sv
// Shared 6-bit PID bus front end: reads the plant measurement, then drives PID output u.
// Compile with MEAS_AVG_EN defined to average each measurement with the previous one.
module pid_bus_frontend #(
    parameter int W            = 6,
    parameter int PHASE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [W-1:0] setpoint,
    input  logic [W-1:0] bus_in,
    output logic [W-1:0] bus_out,
    output logic [W-1:0] bus_oe,
    input  logic [W-1:0] u,
    output logic [W-1:0] e,
    output logic         e_valid,
    output logic [1:0]   phase
);
    localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

    typedef enum logic [1:0] {
        READ   = 2'd0,
        TURN_A = 2'd1,
        WRITE  = 2'd2,
        TURN_B = 2'd3
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           last, capture, latch_u;
    logic [W-1:0]   meas, e_sat, u_hold, u_hold_nx;
    logic [W:0]     diff;
    logic [W-1:0]   bus_oe_nx, bus_out_nx;
    logic           e_valid_nx;

    assign last    = (cnt == CW'(PHASE_CYCLES - 1));
    assign capture = ena && (state == READ) && last;
    assign latch_u = ena && (state == TURN_A);
    assign phase   = state;

`ifdef MEAS_AVG_EN
    logic [W-1:0] meas_prev;
    logic [W:0]   meas_sum;
    assign meas_sum = {1'b0, bus_in} + {1'b0, meas_prev} + (W+1)'(1);
    assign meas     = W'(meas_sum >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       meas_prev <= '0;
        else if (!ena)    meas_prev <= '0;
        else if (capture) meas_prev <= bus_in;
    end
`else
    assign meas = bus_in;
`endif

    // Both operands are unsigned, so bits W and W-1 disagree exactly on overflow.
    assign diff = {1'b0, setpoint} - {1'b0, meas};
    always_comb begin
        case ({diff[W], diff[W-1]})
            2'b01:   e_sat = {1'b0, {(W-1){1'b1}}};
            2'b10:   e_sat = {1'b1, {(W-1){1'b0}}};
            default: e_sat = diff[W-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= READ;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        case (state)
            READ:    if (last) state_nx = TURN_A; else cnt_nx = cnt + CW'(1);
            TURN_A:  state_nx = WRITE;
            WRITE:   if (last) state_nx = TURN_B; else cnt_nx = cnt + CW'(1);
            default: state_nx = READ;
        endcase
        if (!ena) begin
            state_nx = READ;
            cnt_nx   = '0;
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        u_hold_nx  = latch_u ? u : u_hold;
        bus_oe_nx  = (state_nx == WRITE) ? '1 : '0;
        bus_out_nx = (state_nx == WRITE) ? u_hold_nx : '0;
        e_valid_nx = (state_nx == TURN_A);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_oe  <= '0;
            bus_out <= '0;
            e_valid <= 1'b0;
            u_hold  <= '0;
            e       <= '0;
        end else begin
            bus_oe  <= bus_oe_nx;
            bus_out <= bus_out_nx;
            e_valid <= e_valid_nx;
            u_hold  <= u_hold_nx;
            if (capture) e <= e_sat;
        end
    end
endmodule

// File: tb/tb_pid_bus_frontend.sv
// Directed bench for pid_bus_frontend: reset, error/saturation, write path, ena, async reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_pid_bus_frontend;
    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [5:0] setpoint, bus_in, u;
    logic [5:0] bus_out, bus_oe, e;
    logic       e_valid;
    logic [1:0] phase;
    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    int         n;

    pid_bus_frontend #(.W(6), .PHASE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .setpoint(setpoint), .bus_in(bus_in),
        .bus_out(bus_out), .bus_oe(bus_oe), .u(u), .e(e), .e_valid(e_valid), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Counts falling edges until e_valid is seen, bounded at 40.
    task automatic wait_ev(output int cnt_out);
        cnt_out = 0;
        do begin
            @(negedge clk);
            cnt_out++;
        end while (e_valid !== 1'b1 && cnt_out < 40);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; u = 6'h2A;
`ifdef MEAS_AVG_EN
        setpoint = 6'd30; bus_in = 6'd20;
`else
        setpoint = 6'd40; bus_in = 6'd25;
`endif
        repeat (2) @(negedge clk);
        chk("rst_oe", 8'(bus_oe), 8'h00);
        chk("rst_out", 8'(bus_out), 8'h00);
        chk("rst_e", 8'(e), 8'h00);
        chk("rst_ev", 8'(e_valid), 8'h00);
        chk("rst_phase", 8'(phase), 8'h00);
        rst_n = 1'b1;

`ifdef MEAS_AVG_EN
        wait_ev(n);
        chk("avg1_lat", 8'(n), 8'd4);
        chk("avg1_e", 8'(e), 8'd20);
        bus_in = 6'd30;
        wait_ev(n);
        chk("avg2_lat", 8'(n), 8'd10);
        chk("avg2_e", 8'(e), 8'd5);
`else
        // Cycle 1 is the one in which reset releases; e_valid shows in cycle 5.
        wait_ev(n);
        chk("first_ev_edges", 8'(n), 8'd4);
        chk("err_pos", 8'(e), 8'h0F);

        @(negedge clk);
        chk("ev_pulse", 8'(e_valid), 8'h00);
        chk("wr0_oe", 8'(bus_oe), 8'h3F);
        chk("wr0_out", 8'(bus_out), 8'h2A);
        u = 6'h15;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("wr%0d_oe", i), 8'(bus_oe), 8'h3F);
            chk($sformatf("wr%0d_out", i), 8'(bus_out), 8'h2A);
        end
        @(negedge clk);
        chk("turnb_oe", 8'(bus_oe), 8'h00);
        chk("turnb_out", 8'(bus_out), 8'h00);

        setpoint = 6'd10; bus_in = 6'd20;
        wait_ev(n);
        chk("period_a", 8'(n), 8'd5);
        chk("err_neg", 8'(e), 8'h36);

        setpoint = 6'd63; bus_in = 6'd0;
        wait_ev(n);
        chk("period_b", 8'(n), 8'd10);
        chk("sat_pos", 8'(e), 8'h1F);

        setpoint = 6'd0; bus_in = 6'd63;
        wait_ev(n);
        chk("period_c", 8'(n), 8'd10);
        chk("sat_neg", 8'(e), 8'h20);

        @(negedge clk);
        chk("ena_wr_oe", 8'(bus_oe), 8'h3F);
        chk("ena_wr_out", 8'(bus_out), 8'h15);
        ena = 1'b0;
        @(negedge clk);
        chk("ena_drop_oe", 8'(bus_oe), 8'h00);
        chk("ena_drop_out", 8'(bus_out), 8'h00);
        chk("ena_drop_e", 8'(e), 8'h20);
        chk("ena_drop_phase", 8'(phase), 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("ena_idle%0d_ev", i), 8'(e_valid), 8'h00);
        end
        setpoint = 6'd5; bus_in = 6'd5;
        ena = 1'b1;
        wait_ev(n);
        chk("ena_rise_edges", 8'(n), 8'd4);
        chk("ena_rise_e", 8'(e), 8'h00);

        setpoint = 6'd50; bus_in = 6'd10;
        wait_ev(n);
        chk("pre_rst_e", 8'(e), 8'h1F);
        @(negedge clk);
        chk("pre_rst_oe", 8'(bus_oe), 8'h3F);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe", 8'(bus_oe), 8'h00);
        chk("arst_out", 8'(bus_out), 8'h00);
        chk("arst_e", 8'(e), 8'h00);
        chk("arst_ev", 8'(e_valid), 8'h00);
        chk("arst_phase", 8'(phase), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
